state_tx: RTL and testbench

STATE_TX -- requirements
Module: state_tx

---
 rtl/state_link_pkg.sv | 50 +++++
 rtl/tx_period_timer.sv | 40 ++++
 rtl/state_tx.sv | 97 +++++++++
 tb/tb_state_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_link_pkg.sv
// rtl/state_link_pkg.sv - shared packet layout, field widths and link state enum
package state_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PKT_LEN       = 7;
    localparam int         IDX_W         = 3;

    localparam int X_W      = 11;
    localparam int Y_W      = 11;
    localparam int DIR_W    = 9;
    localparam int STATUS_W = 3;
    localparam int SEQ_W    = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } link_state_e;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [DIR_W-1:0]    dir;
        logic [STATUS_W-1:0] status;
        logic [SEQ_W-1:0]    seq;
    } link_fields_t;

    // Byte idx of a packet; the last byte is the XOR of the five payload bytes.
    function automatic logic [7:0] pkt_byte(input link_fields_t f,
                                            input logic [7:0] sync,
                                            input logic [IDX_W-1:0] idx);
        logic [7:0] b1, b2, b3, b4, b5, res;
        b1 = f.x[10:3];
        b2 = {f.x[2:0], f.y[10:6]};
        b3 = {f.y[5:0], f.dir[8:7]};
        b4 = {f.dir[6:0], f.status[2]};
        b5 = {f.status[1:0], f.seq};
        case (idx)
            3'd0:    res = sync;
            3'd1:    res = b1;
            3'd2:    res = b2;
            3'd3:    res = b3;
            3'd4:    res = b4;
            3'd5:    res = b5;
            3'd6:    res = b1 ^ b2 ^ b3 ^ b4 ^ b5;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tx_period_timer.sv
// rtl/tx_period_timer.sv - free-running send period counter and trigger merge
module tx_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 1666667
) (
    input  logic clk,
    input  logic rst_n,
    input  logic send_req_i,
    output logic trigger_o
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0);
    localparam bit TIMER_ON = (PERIOD_CYCLES > 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap      = TIMER_ON && (cnt_q == CNT_LAST);
    assign trigger_o = send_req_i | wrap;

    // Counter wraps at the period end; held at zero when the timer is disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!TIMER_ON || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register; runs regardless of downstream backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/state_tx.sv
// rtl/state_tx.sv - kart state packet transmitter with pending-request collapse
module state_tx
    import state_link_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 1666667,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send_req,
    input  logic [X_W-1:0]      player_x,
    input  logic [Y_W-1:0]      player_y,
    input  logic [DIR_W-1:0]    player_dir,
    input  logic [STATUS_W-1:0] game_status,
    output logic                axiov,
    output logic [7:0]          axiod,
    output logic                axil,
    input  logic                axir,
    output logic                busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    link_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    link_fields_t      snap_q, snap_d;
    logic              trigger;

    tx_period_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_req_i (send_req),
        .trigger_o  (trigger)
    );

    // Output bytes come straight from the frozen snapshot, so they hold while stalled.
    assign axiov = (state_q == ST_SEND);
    assign axiod = axiov ? pkt_byte(snap_q, SYNC_BYTE, idx_q) : 8'h00;
    assign axil  = axiov && (idx_q == LAST_IDX);
    assign busy  = axiov | pend_q;

    // Packet sequencing: a pending request forces the one idle cycle between packets.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger || pend_q) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    seq_d   = seq_q + SEQ_W'(1);
                    snap_d  = '{x: player_x, y: player_y, dir: player_dir,
                                status: game_status, seq: seq_q};
                end
            end
            ST_SEND: begin
                if (trigger) begin
                    pend_d = 1'b1;
                end
                if (axir) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            seq_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_state_tx.sv
// tb/tb_state_tx.sv - self-checking bench for state_tx
module tb_state_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_req = 1'b0;
    logic [10:0] player_x = 11'd100;
    logic [10:0] player_y = 11'd100;
    logic [8:0]  player_dir = 9'd90;
    logic [2:0]  game_status = 3'd1;
    logic        axir = 1'b1;
    logic        axiov, axil, busy;
    logic [7:0]  axiod;

    logic        p_send_req = 1'b0;
    logic        p_axir = 1'b1;
    logic        p_axiov, p_axil, p_busy;
    logic [7:0]  p_axiod;

    always #5 clk = ~clk;

    state_tx #(.PERIOD_CYCLES(0), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .send_req(send_req),
        .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
        .game_status(game_status),
        .axiov(axiov), .axiod(axiod), .axil(axil), .axir(axir), .busy(busy)
    );

    state_tx #(.PERIOD_CYCLES(20), .SYNC_BYTE(8'hA5)) dut_p (
        .clk(clk), .rst_n(rst_n), .send_req(p_send_req),
        .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
        .game_status(game_status),
        .axiov(p_axiov), .axiod(p_axiod), .axil(p_axil), .axir(p_axir), .busy(p_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // transaction-level reference: packet in flight, byte position, pending flag, seq
    bit m_send = 0;
    int m_idx  = 0;
    bit m_pend = 0;
    int m_seq  = 0;
    int m_bytes[7];

    logic [7:0] rx_q[$];
    bit         hist[$];
    int         pkts = 0;

    bit p_en = 0;
    int p_bcnt = 0, p_pkt = 0, p_starts = 0, p_last = 0;
    bit p_prev_v = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_pkt(input int x, input int y, input int d, input int st, input int sq);
        m_bytes[0] = 'hA5;
        m_bytes[1] = x / 8;
        m_bytes[2] = (x % 8) * 32 + y / 64;
        m_bytes[3] = (y % 64) * 4 + d / 128;
        m_bytes[4] = (d % 128) * 2 + st / 4;
        m_bytes[5] = (st % 4) * 64 + sq;
        m_bytes[6] = m_bytes[1] ^ m_bytes[2] ^ m_bytes[3] ^ m_bytes[4] ^ m_bytes[5];
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            m_send = 0; m_idx = 0; m_pend = 0; m_seq = 0;
        end else if (!m_send) begin
            if (send_req || m_pend) begin
                build_pkt(player_x, player_y, player_dir, game_status, m_seq);
                m_seq  = (m_seq + 1) % 64;
                m_send = 1; m_idx = 0; m_pend = 0;
            end
        end else begin
            if (send_req) m_pend = 1;
            if (axir) begin
                if (m_idx == 6) m_send = 0;
                else m_idx++;
            end
        end
    endfunction

    task automatic tick();
        if (axiov && axir) begin
            rx_q.push_back(axiod);
            if (axil) pkts++;
        end
        if (p_en && p_axiov) begin
            if (p_bcnt == 0) check("period_sync", p_axiod, 8'hA5);
            if (p_bcnt == 5) begin
                check("period_seq", p_axiod[5:0], p_pkt % 64);
                p_pkt++;
            end
            p_bcnt = (p_bcnt == 6) ? 0 : p_bcnt + 1;
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        hist.push_back(axiov);
        check("model_axiov", axiov, m_send);
        check("model_axiod", axiod, m_send ? m_bytes[m_idx] : 0);
        check("model_axil", axil, (m_send && m_idx == 6) ? 1 : 0);
        check("model_busy", busy, (m_send || m_pend) ? 1 : 0);
        if (p_en && p_axiov && !p_prev_v) begin
            if (p_starts > 0) check("period_gap", cyc - p_last, 20);
            p_last = cyc;
            p_starts++;
        end
        p_prev_v = p_axiov;
    endtask

    task automatic pulse();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic do_reset();
        send_req = 1'b0;
        axir = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          x, y, d, st;
        logic [55:0] bytes;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{x: 100,  y: 100,  d: 90,  st: 1, bytes: 56'hA5_0C_81_90_B4_40_E9};
        vecs[1] = '{x: 2047, y: 0,    d: 0,   st: 0, bytes: 56'hA5_FF_E0_00_00_01_1E};
        vecs[2] = '{x: 0,    y: 2047, d: 359, st: 7, bytes: 56'hA5_00_1F_FE_CF_C2_EC};

        do_reset();
        check("reset_axiov", axiov, 0);
        check("reset_axiod", axiod, 0);
        check("reset_axil", axil, 0);
        check("reset_busy", busy, 0);

        // table-driven packets back to back, seq 0,1,2
        for (int v = 0; v < 3; v++) begin
            player_x = 11'(vecs[v].x); player_y = 11'(vecs[v].y);
            player_dir = 9'(vecs[v].d); game_status = 3'(vecs[v].st);
            pulse();
            for (int i = 0; i < 7; i++) begin
                check("vec_byte", axiod, vecs[v].bytes[8*(6-i) +: 8]);
                check("vec_last", axil, (i == 6) ? 1 : 0);
                check("vec_valid", axiov, 1);
                tick();
            end
            check("vec_end_valid", axiov, 0);
            tick();
        end

        // backpressure during B3
        player_x = 11'd100; player_y = 11'd100; player_dir = 9'd90; game_status = 3'd1;
        pulse();
        tick(); tick(); tick();
        axir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_b3", axiod, 8'h90);
            check("stall_last", axil, 0);
            tick();
        end
        axir = 1'b1;
        check("stall_b3_release", axiod, 8'h90);
        tick();
        check("stall_b4", axiod, 8'hB4);
        for (int n = 0; n < 30 && busy; n++) tick();
        check("stall_drain", busy, 0);

        // three requests during one packet collapse into one
        do_reset();
        rx_q.delete(); hist.delete(); pkts = 0;
        pulse();
        for (int k = 0; k < 3; k++) pulse();
        for (int n = 0; n < 25; n++) tick();
        check("collapse_pkts", pkts, 2);
        check("collapse_bytes", rx_q.size(), 14);
        if (rx_q.size() >= 14) begin
            check("collapse_seq0", rx_q[5], 8'h40);
            check("collapse_seq1", rx_q[12], 8'h41);
        end
        begin
            int i = 0, gap = 0;
            while (i < hist.size() && hist[i]) i++;
            while (i < hist.size() && !hist[i]) begin gap++; i++; end
            check("collapse_gap", gap, 1);
        end

        // input change mid-packet
        do_reset();
        rx_q.delete();
        pulse();
        tick(); tick();
        player_x = 11'd500;
        pulse();
        for (int n = 0; n < 25; n++) tick();
        check("snap_bytes", rx_q.size(), 14);
        if (rx_q.size() >= 14) begin
            check("snap_old_x", rx_q[1], 8'h0C);
            check("snap_new_x", rx_q[8], 8'h3E);
        end
        player_x = 11'd100;

        // reset during B4
        do_reset();
        pulse();
        tick(); tick(); tick(); tick();
        check("abort_at_b4", axiod, 8'hB4);
        rst_n = 1'b0;
        tick();
        check("abort_axiov", axiov, 0);
        check("abort_busy", busy, 0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("abort_no_resume", axiov, 0);
        rx_q.delete();
        pulse();
        check("abort_restart_b0", axiod, 8'hA5);
        for (int n = 0; n < 8; n++) tick();
        check("abort_restart_len", rx_q.size(), 7);
        if (rx_q.size() >= 7) begin
            check("abort_restart_seq", rx_q[5], 8'h40);
            check("abort_restart_cks", rx_q[6], 8'hE9);
        end

        // periodic sending
        do_reset();
        p_en = 1; p_bcnt = 0; p_pkt = 0; p_starts = 0; p_prev_v = 0;
        for (int n = 0; n < 64 * 20 + 60; n++) tick();
        p_en = 0;
        check("period_pkts_ge65", (p_pkt >= 65) ? 1 : 0, 1);

        // randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            send_req    = ($urandom_range(0, 7) == 0);
            axir        = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            player_x    = 11'($urandom);
            player_y    = 11'($urandom);
            player_dir  = 9'($urandom_range(0, 359));
            game_status = 3'($urandom);
            tick();
        end
        send_req = 1'b0; rst_n = 1'b1; axir = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
